// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl (with leaf cell full_adder)
// Description : Bit-serial adder controller. Accepts two WIDTH-bit operands
//               plus carry-in over a valid/ready handshake, sequences one
//               full_adder cell LSB first (one bit per clock), and returns
//               the WIDTH-bit sum and carry-out over a second handshake.
//               Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' port
//               selecting a - b (two's complement) instead of a + b + cin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Single-bit full adder cell
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q,  a_sh_d;
   logic [WIDTH-1:0] b_sh_q,  b_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;

   logic             w_fa_s;
   logic             w_fa_co;
   logic [WIDTH:0]   w_sum_ext;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   // Operand B and initial carry as loaded at acceptance; subtraction is
   // a + ~b + 1, so the carry-in port is ignored when sub is set.
`ifdef SERIAL_ADD_SUB_EN
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   full_adder u_fa (
      .a_i  (a_sh_q[0]),
      .b_i  (b_sh_q[0]),
      .ci_i (carry_q),
      .s_o  (w_fa_s),
      .co_o (w_fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign w_sum_ext = {w_fa_s, sum_q};

   // Next-state logic for the sequencer and datapath shift registers
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = w_b_load;
               carry_d = w_c_load;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d   = w_sum_ext[WIDTH:1];
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = w_fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cout_d  = w_fa_co;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Result is held until the consumer takes it
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl. Drives a WIDTH=8
//               and a WIDTH=1 instance with directed vectors and random
//               back-to-back operations with output stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_valid_v;
   logic [1:0] out_ready_v;
   logic [1:0] cin_v;
   logic [1:0] sub_v;
   logic [7:0] a_v [2];
   logic [7:0] b_v [2];

   logic [1:0] in_ready_v;
   logic [1:0] out_valid_v;
   logic [1:0] busy_v;
   logic [1:0] cout_v;
   logic [7:0] sum8;
   logic [0:0] sum1;
   logic [7:0] sum_v [2];

   int n_chk;
   int n_fail;

   assign sum_v[0] = sum8;
   assign sum_v[1] = {7'd0, sum1};

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[0]),
      .in_ready  (in_ready_v[0]),
      .a         (a_v[0]),
      .b         (b_v[0]),
      .cin       (cin_v[0]),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub_v[0]),
`endif
      .out_valid (out_valid_v[0]),
      .out_ready (out_ready_v[0]),
      .sum       (sum8),
      .cout      (cout_v[0]),
      .busy      (busy_v[0])
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[1]),
      .in_ready  (in_ready_v[1]),
      .a         (a_v[1][0:0]),
      .b         (b_v[1][0:0]),
      .cin       (cin_v[1]),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub_v[1]),
`endif
      .out_valid (out_valid_v[1]),
      .out_ready (out_ready_v[1]),
      .sum       (sum1),
      .cout      (cout_v[1]),
      .busy      (busy_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference result {cout, sum} for width w, bits above w are zero
   function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sb);
      logic [8:0] m;
      logic [8:0] t;
      m = (9'd1 << w) - 9'd1;
      t = ({1'b0, a} & m) + ({1'b0, (sb ? ~b : b)} & m) + {8'd0, (sb ? 1'b1 : ci)};
      return t;
   endfunction

   // One full transaction on instance d (0: WIDTH=8, 1: WIDTH=1), with
   // 'stall' DONE cycles of out_ready=0 and ignored in_valid pulses.
   task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input logic [7:0] es, input logic ec, input int stall);
      int w;
      int lat;
      w   = (d == 0) ? 8 : 1;
      lat = 0;
      while (!in_ready_v[d] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk_val("in_ready_idle", 32'(in_ready_v[d]), 32'd1);
      in_valid_v[d] = 1'b1;
      a_v[d]        = a;
      b_v[d]        = b;
      cin_v[d]      = ci;
      sub_v[d]      = sb;
      @(posedge clk); #1;
      in_valid_v[d] = 1'b0;
      chk_val("in_ready_run", 32'(in_ready_v[d]), 32'd0);
      lat = 0;
      while (!out_valid_v[d] && lat < 100) begin
         chk_val("busy_run", 32'(busy_v[d]), 32'd1);
         a_v[d]         = 8'($urandom);
         b_v[d]         = 8'($urandom);
         cin_v[d]       = 1'($urandom);
         sub_v[d]       = 1'($urandom);
         in_valid_v[d]  = 1'($urandom);
         out_ready_v[d] = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b0;
      chk_val("latency", 32'(lat), 32'(w));
      chk_val("sum", 32'(sum_v[d]), 32'(es));
      chk_val("cout", 32'(cout_v[d]), 32'(ec));
      chk_val("busy_done", 32'(busy_v[d]), 32'd1);
      chk_val("in_ready_done", 32'(in_ready_v[d]), 32'd0);
      for (int s = 0; s < stall; s++) begin
         in_valid_v[d] = 1'b1;
         a_v[d]        = 8'($urandom);
         b_v[d]        = 8'($urandom);
         @(posedge clk); #1;
         chk_val("stall_out_valid", 32'(out_valid_v[d]), 32'd1);
         chk_val("stall_in_ready", 32'(in_ready_v[d]), 32'd0);
         chk_val("stall_sum", 32'(sum_v[d]), 32'(es));
         chk_val("stall_cout", 32'(cout_v[d]), 32'(ec));
      end
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[d] = 1'b0;
      chk_val("release_out_valid", 32'(out_valid_v[d]), 32'd0);
      chk_val("release_in_ready", 32'(in_ready_v[d]), 32'd1);
      chk_val("release_busy", 32'(busy_v[d]), 32'd0);
      chk_val("idle_sum_kept", 32'(sum_v[d]), 32'(es));
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rs;
      logic [8:0] r;
      logic [7:0] m8;
      int         w;

      n_chk       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      in_valid_v  = '0;
      out_ready_v = '0;
      cin_v       = '0;
      sub_v       = '0;
      a_v[0]      = '0;
      a_v[1]      = '0;
      b_v[0]      = '0;
      b_v[1]      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state of both instances
      for (int d = 0; d < 2; d++) begin
         chk_val("rst_in_ready", 32'(in_ready_v[d]), 32'd1);
         chk_val("rst_out_valid", 32'(out_valid_v[d]), 32'd0);
         chk_val("rst_busy", 32'(busy_v[d]), 32'd0);
         chk_val("rst_sum", 32'(sum_v[d]), 32'd0);
         chk_val("rst_cout", 32'(cout_v[d]), 32'd0);
      end

      // Directed additions, WIDTH=8
      do_op(0, 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 0);
      do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
      do_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0);
      // Backpressure: 5 stalled DONE cycles with ignored in_valid pulses
      do_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 5);

      // Reset asserted during the 3rd RUN cycle
      in_valid_v[0] = 1'b1;
      a_v[0]        = 8'hAA;
      b_v[0]        = 8'h55;
      cin_v[0]      = 1'b0;
      sub_v[0]      = 1'b0;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk_val("midrun_busy", 32'(busy_v[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_val("arst_in_ready", 32'(in_ready_v[0]), 32'd1);
      chk_val("arst_out_valid", 32'(out_valid_v[0]), 32'd0);
      chk_val("arst_busy", 32'(busy_v[0]), 32'd0);
      chk_val("arst_sum", 32'(sum_v[0]), 32'd0);
      chk_val("arst_cout", 32'(cout_v[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk_val("post_rst_no_valid", 32'(out_valid_v[0]), 32'd0);
      end
      do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      do_op(0, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
      do_op(0, 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 0);
`endif

      // Random back-to-back operations on both widths
      for (int d = 0; d < 2; d++) begin
         w  = (d == 0) ? 8 : 1;
         m8 = (d == 0) ? 8'hFF : 8'h01;
         for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(w, ra, rb, rc, rs);
            do_op(d, ra, rb, rc, rs, r[7:0] & m8, r[w], int'($urandom_range(0, 3)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
